dmem_read_arbiter: RTL and testbench
====================================

DMEM_READ_ARBITER -- requirements
Module: dmem_read_arbiter

Interface
REQ-001 Parameter DMEM_READ_ARB_Q_DEPTH, default 2, is the per-port pending request queue depth (power of 2, >=2).
REQ-002 CLK  input  1  clock; all state updates on its rising edge.
REQ-003 nRST  input  1  reset; asynchronous, active-low.
REQ-004 DUT_error  output  1  sticky protocol-error flag.
REQ-005 dmem0_read_req_valid  input  1  one-cycle pulse; no back-pressure to the requester.
REQ-006 dmem0_read_req_block_addr  input  block_addr_t  block address of the port 0 request.
REQ-007 dmem0_read_resp_valid  output  1  port 0 response strobe.
REQ-008 dmem0_read_resp_data  output  word_t[1:0]  port 0 response block data.
REQ-009 dmem1_read_req_valid, dmem1_read_req_block_addr, dmem1_read_resp_valid, dmem1_read_resp_data: same as REQ-005..008, for port 1.
REQ-010 mem_read_req_valid  output  1  single shared memory read request.
REQ-011 mem_read_req_block_addr  output  block_addr_t  address of the granted request.
REQ-012 mem_read_req_ready  input  1  memory accepts the request this cycle.
REQ-013 mem_read_resp_valid  input  1  memory read data valid.
REQ-014 mem_read_resp_data  input  word_t[1:0]  memory read data.

Function
REQ-015 Each port SHALL have a FIFO of depth DMEM_READ_ARB_Q_DEPTH; a valid pulse enqueues the address at the clock edge.
- Head/tail pointers carry an msb wrap bit.
- Full: same index, msb differs. Empty: pointers equal.
REQ-016 An enqueue to a full FIFO SHALL be dropped and SHALL set DUT_error, unless that FIFO pops in the same cycle; in that case the enqueue is accepted.
REQ-017 The FSM SHALL have three states: IDLE, ISSUE and WAIT.
REQ-018 IDLE: if either FIFO is non-empty, the arbiter SHALL latch the grant port and the head address, then go to ISSUE; otherwise it stays in IDLE.
REQ-019 Arbitration SHALL be round-robin. When both FIFOs are non-empty, the port that was not granted last wins; a single non-empty FIFO always wins.
REQ-020 ISSUE: mem_read_req_valid=1 and mem_read_req_block_addr=latched address.
- ready=1: pop the granted FIFO, go to WAIT.
- ready=0: hold valid and address stable, stay in ISSUE.
REQ-021 WAIT: mem_read_resp_valid=1 SHALL combinationally drive the granted port's resp_valid=1 and resp_data=mem_read_resp_data in the same cycle, then go to IDLE.
REQ-022 Minimum latency: a request pulse in cycle N to an empty arbiter SHALL produce mem_read_req_valid in cycle N+2.
REQ-023 mem_read_resp_valid outside WAIT SHALL be ignored and SHALL set DUT_error.
REQ-024 When not in ISSUE: mem_read_req_valid=0 and mem_read_req_block_addr=0. resp_valid is 0 on both ports except in the REQ-021 cycle, and resp_data=0 on both ports whenever its resp_valid=0.
REQ-025 At most one memory read SHALL be outstanding at any time.
REQ-026 A request arriving in the same cycle its FIFO is popped SHALL be enqueued normally.

Reset
REQ-027 Reset SHALL set: state=IDLE; all FIFO pointers=0; latched grant/address=0; last-grant=port 1, so port 0 wins the first tie; DUT_error=0; all outputs=0.
REQ-028 Reset mid-operation SHALL discard all queued and in-flight requests. A later stray memory response is handled per REQ-023.

Configuration
REQ-029 With DMEM_READ_ARB_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority with port 0 always winning, and the last-grant register is not implemented.
REQ-030 Without DMEM_READ_ARB_FIXED_PRIO_EN defined, arbitration SHALL be round-robin per REQ-019.

Verification
REQ-031 Single request: port 0 pulse with addr 0x100 in cycle 0, ready=1 -> mem_read_req_valid=1 with addr 0x100 in cycle 2; resp in cycle 5 with data {0xA,0xB} -> dmem0_read_resp_valid=1 with that data in cycle 5, port 1 resp_valid stays 0.
REQ-032 Contention: both ports pulse in the same cycle (addrs 0x10 and 0x20) -> grant order port 0 then port 1; with FIXED_PRIO and repeated requests on both ports, port 0 always wins.
REQ-033 Back-pressure: ready=0 for 4 cycles -> mem_read_req_valid and addr held stable; no pop until ready=1.
REQ-034 Overflow: 3 pulses on port 1 while ISSUE is stalled, DEPTH=2 -> third request dropped, DUT_error=1; first two requests issued in order.
REQ-035 Errors and reset: mem_read_resp_valid in IDLE -> DUT_error=1, no port response; nRST asserted in WAIT -> state IDLE and FIFOs empty on the next cycle.

Source files
------------

// File: rtl/dmem_read_arbiter.sv
// Two-port read arbiter: per-port request FIFOs feed a single memory read port, one read outstanding.
// Define DMEM_READ_ARB_FIXED_PRIO_EN for fixed port-0 priority; default build is round-robin.
module dmem_read_arbiter #(
  parameter int DMEM_READ_ARB_Q_DEPTH = 2,
  parameter int BLOCK_ADDR_W          = 29,
  parameter int WORD_W                = 32
) (
  input  logic                    CLK,
  input  logic                    nRST,
  output logic                    DUT_error,
  input  logic                    dmem0_read_req_valid,
  input  logic [BLOCK_ADDR_W-1:0] dmem0_read_req_block_addr,
  output logic                    dmem0_read_resp_valid,
  output logic [2*WORD_W-1:0]     dmem0_read_resp_data,
  input  logic                    dmem1_read_req_valid,
  input  logic [BLOCK_ADDR_W-1:0] dmem1_read_req_block_addr,
  output logic                    dmem1_read_resp_valid,
  output logic [2*WORD_W-1:0]     dmem1_read_resp_data,
  output logic                    mem_read_req_valid,
  output logic [BLOCK_ADDR_W-1:0] mem_read_req_block_addr,
  input  logic                    mem_read_req_ready,
  input  logic                    mem_read_resp_valid,
  input  logic [2*WORD_W-1:0]     mem_read_resp_data
);

  localparam int IDX_W = $clog2(DMEM_READ_ARB_Q_DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t                  state_r;
  logic                    grant_r;
  logic                    req_valid_r;
  logic [BLOCK_ADDR_W-1:0] req_addr_r;
  logic                    error_r;
`ifndef DMEM_READ_ARB_FIXED_PRIO_EN
  logic                    last_grant_r;
`endif

  logic [PTR_W-1:0]        head_r [2];
  logic [PTR_W-1:0]        tail_r [2];
  logic [BLOCK_ADDR_W-1:0] fifo_r [2][DMEM_READ_ARB_Q_DEPTH];

  logic [1:0]              req_valid_s;
  logic [BLOCK_ADDR_W-1:0] req_addr_s [2];
  logic [BLOCK_ADDR_W-1:0] head_addr_s [2];
  logic [1:0]              empty_s;
  logic [1:0]              full_s;
  logic [1:0]              push_s;
  logic [1:0]              pop_s;
  logic                    overflow_s;
  logic                    any_pending_s;
  logic                    next_grant_s;
  logic                    stray_resp_s;
  logic                    resp_hit_s;

  assign req_valid_s   = {dmem1_read_req_valid, dmem0_read_req_valid};
  assign req_addr_s[0] = dmem0_read_req_block_addr;
  assign req_addr_s[1] = dmem1_read_req_block_addr;

  // FIFO status; a pop in the same cycle frees the slot for an incoming request
  always_comb begin
    overflow_s = 1'b0;
    for (int p = 0; p < 2; p++) begin
      empty_s[p]     = (head_r[p] == tail_r[p]);
      full_s[p]      = (head_r[p][IDX_W-1:0] == tail_r[p][IDX_W-1:0]) &&
                       (head_r[p][IDX_W] != tail_r[p][IDX_W]);
      pop_s[p]       = (state_r == ISSUE) && mem_read_req_ready && (grant_r == 1'(p));
      push_s[p]      = req_valid_s[p] && (!full_s[p] || pop_s[p]);
      head_addr_s[p] = fifo_r[p][head_r[p][IDX_W-1:0]];
      overflow_s     = overflow_s | (req_valid_s[p] && full_s[p] && !pop_s[p]);
    end
  end

  // Grant selection among non-empty FIFOs
  always_comb begin
    any_pending_s = !empty_s[0] || !empty_s[1];
`ifdef DMEM_READ_ARB_FIXED_PRIO_EN
    if (!empty_s[0]) begin
      next_grant_s = 1'b0;
    end else begin
      next_grant_s = 1'b1;
    end
`else
    if (!empty_s[0] && !empty_s[1]) begin
      next_grant_s = ~last_grant_r;
    end else if (!empty_s[0]) begin
      next_grant_s = 1'b0;
    end else begin
      next_grant_s = 1'b1;
    end
`endif
  end

  // Per-port FIFO storage and pointers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int p = 0; p < 2; p++) begin
        head_r[p] <= '0;
        tail_r[p] <= '0;
        for (int i = 0; i < DMEM_READ_ARB_Q_DEPTH; i++) begin
          fifo_r[p][i] <= '0;
        end
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (push_s[p]) begin
          fifo_r[p][tail_r[p][IDX_W-1:0]] <= req_addr_s[p];
          tail_r[p] <= tail_r[p] + PTR_ONE;
        end
        if (pop_s[p]) begin
          head_r[p] <= head_r[p] + PTR_ONE;
        end
      end
    end
  end

  // Arbitration FSM; request outputs are registered alongside the state
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r      <= IDLE;
      grant_r      <= 1'b0;
      req_valid_r  <= 1'b0;
      req_addr_r   <= '0;
`ifndef DMEM_READ_ARB_FIXED_PRIO_EN
      last_grant_r <= 1'b1;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (any_pending_s) begin
            state_r      <= ISSUE;
            grant_r      <= next_grant_s;
            req_valid_r  <= 1'b1;
            req_addr_r   <= head_addr_s[next_grant_s];
`ifndef DMEM_READ_ARB_FIXED_PRIO_EN
            last_grant_r <= next_grant_s;
`endif
          end
        end
        ISSUE: begin
          if (mem_read_req_ready) begin
            state_r     <= WAIT;
            req_valid_r <= 1'b0;
            req_addr_r  <= '0;
          end
        end
        WAIT: begin
          if (mem_read_resp_valid) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          req_valid_r <= 1'b0;
          req_addr_r  <= '0;
        end
      endcase
    end
  end

  assign stray_resp_s = mem_read_resp_valid && (state_r != WAIT);

  // Sticky protocol error: FIFO overflow or response with no read outstanding
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      error_r <= 1'b0;
    end else if (overflow_s || stray_resp_s) begin
      error_r <= 1'b1;
    end
  end

  // Responses pass straight through to the granted port in the completing cycle
  always_comb begin
    resp_hit_s            = (state_r == WAIT) && mem_read_resp_valid;
    dmem0_read_resp_valid = resp_hit_s && !grant_r;
    dmem1_read_resp_valid = resp_hit_s && grant_r;
    if (dmem0_read_resp_valid) begin
      dmem0_read_resp_data = mem_read_resp_data;
    end else begin
      dmem0_read_resp_data = '0;
    end
    if (dmem1_read_resp_valid) begin
      dmem1_read_resp_data = mem_read_resp_data;
    end else begin
      dmem1_read_resp_data = '0;
    end
  end

  assign mem_read_req_valid      = req_valid_r;
  assign mem_read_req_block_addr = req_addr_r;
  assign DUT_error               = error_r;

endmodule

// File: tb/tb_dmem_read_arbiter.sv
// Scoreboard bench for dmem_read_arbiter: directed stimulus pushes expected issues/responses,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_dmem_read_arbiter;

  localparam int AW = 29;
  localparam int WW = 32;

  logic              CLK;
  logic              nRST;
  logic              DUT_error;
  logic              dmem0_read_req_valid;
  logic [AW-1:0]     dmem0_read_req_block_addr;
  logic              dmem0_read_resp_valid;
  logic [2*WW-1:0]   dmem0_read_resp_data;
  logic              dmem1_read_req_valid;
  logic [AW-1:0]     dmem1_read_req_block_addr;
  logic              dmem1_read_resp_valid;
  logic [2*WW-1:0]   dmem1_read_resp_data;
  logic              mem_read_req_valid;
  logic [AW-1:0]     mem_read_req_block_addr;
  logic              mem_read_req_ready;
  logic              mem_read_resp_valid;
  logic [2*WW-1:0]   mem_read_resp_data;

  int vectors;
  int miscompares;

  logic [AW-1:0]   exp_issue [$];
  logic [2*WW-1:0] exp_resp0 [$];
  logic [2*WW-1:0] exp_resp1 [$];

  dmem_read_arbiter dut (
    .CLK                       (CLK),
    .nRST                      (nRST),
    .DUT_error                 (DUT_error),
    .dmem0_read_req_valid      (dmem0_read_req_valid),
    .dmem0_read_req_block_addr (dmem0_read_req_block_addr),
    .dmem0_read_resp_valid     (dmem0_read_resp_valid),
    .dmem0_read_resp_data      (dmem0_read_resp_data),
    .dmem1_read_req_valid      (dmem1_read_req_valid),
    .dmem1_read_req_block_addr (dmem1_read_req_block_addr),
    .dmem1_read_resp_valid     (dmem1_read_resp_valid),
    .dmem1_read_resp_data      (dmem1_read_resp_data),
    .mem_read_req_valid        (mem_read_req_valid),
    .mem_read_req_block_addr   (mem_read_req_block_addr),
    .mem_read_req_ready        (mem_read_req_ready),
    .mem_read_resp_valid       (mem_read_resp_valid),
    .mem_read_resp_data        (mem_read_resp_data)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  function automatic logic [2*WW-1:0] resp_of(input logic [AW-1:0] a);
    return {32'hA000_0000 | 32'(a), 32'hB000_0000 | 32'(a)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic fail_unexpected(input string name, input logic [63:0] act);
    vectors++;
    miscompares++;
    $display("FAIL %s: got %0h, required no output", name, act);
  endtask

  // Monitor: every accepted issue and every port response is matched against the scoreboard
  always @(negedge CLK) begin
    if (nRST) begin
      if (mem_read_req_valid && mem_read_req_ready) begin
        if (exp_issue.size() == 0) fail_unexpected("issue_unexpected", 64'(mem_read_req_block_addr));
        else check("issue_addr", 64'(mem_read_req_block_addr), 64'(exp_issue.pop_front()));
      end
      if (dmem0_read_resp_valid) begin
        if (exp_resp0.size() == 0) fail_unexpected("resp0_unexpected", dmem0_read_resp_data);
        else check("resp0_data", dmem0_read_resp_data, exp_resp0.pop_front());
      end else if (dmem0_read_resp_data != '0) begin
        fail_unexpected("resp0_idle_data", dmem0_read_resp_data);
      end
      if (dmem1_read_resp_valid) begin
        if (exp_resp1.size() == 0) fail_unexpected("resp1_unexpected", dmem1_read_resp_data);
        else check("resp1_data", dmem1_read_resp_data, exp_resp1.pop_front());
      end else if (dmem1_read_resp_data != '0) begin
        fail_unexpected("resp1_idle_data", dmem1_read_resp_data);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_cycle(input logic v0, input logic [AW-1:0] a0,
                             input logic v1, input logic [AW-1:0] a1,
                             input logic rv, input logic [2*WW-1:0] rd);
    dmem0_read_req_valid      = v0;
    dmem0_read_req_block_addr = a0;
    dmem1_read_req_valid      = v1;
    dmem1_read_req_block_addr = a1;
    mem_read_resp_valid       = rv;
    mem_read_resp_data        = rd;
    tick();
    dmem0_read_req_valid      = 1'b0;
    dmem0_read_req_block_addr = '0;
    dmem1_read_req_valid      = 1'b0;
    dmem1_read_req_block_addr = '0;
    mem_read_resp_valid       = 1'b0;
    mem_read_resp_data        = '0;
  endtask

  task automatic wait_issue(input string name);
    int n = 0;
    while (!mem_read_req_valid && n < 20) begin
      tick();
      n++;
    end
    if (!mem_read_req_valid) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: got no mem_read_req_valid, required one within 20 cycles", name);
    end
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    drive_cycle(1'b0, '0, 1'b0, '0, 1'b0, '0);
    mem_read_req_ready = 1'b1;
    check("rst_req_valid", 64'(mem_read_req_valid), 64'd0);
    check("rst_req_addr", 64'(mem_read_req_block_addr), 64'd0);
    check("rst_error", 64'(DUT_error), 64'd0);
    check("rst_resp_valid", 64'({dmem1_read_resp_valid, dmem0_read_resp_valid}), 64'd0);
    nRST = 1'b1;
    tick();
  endtask

  initial begin
    logic [AW-1:0] order [4];
    vectors     = 0;
    miscompares = 0;
    nRST = 1'b0;
    mem_read_req_ready = 1'b1;
    dmem0_read_req_valid = 1'b0; dmem0_read_req_block_addr = '0;
    dmem1_read_req_valid = 1'b0; dmem1_read_req_block_addr = '0;
    mem_read_resp_valid  = 1'b0; mem_read_resp_data = '0;

    // Single request: issue in cycle 2, response in cycle 5
    do_reset();
    exp_issue.push_back(29'h100);
    exp_resp0.push_back({32'h0000_000A, 32'h0000_000B});
    drive_cycle(1'b1, 29'h100, 1'b0, '0, 1'b0, '0);
    check("lat_cycle1_valid", 64'(mem_read_req_valid), 64'd0);
    tick();
    check("lat_cycle2_valid", 64'(mem_read_req_valid), 64'd1);
    tick();
    check("wait_valid_low", 64'(mem_read_req_valid), 64'd0);
    tick();
    tick();
    drive_cycle(1'b0, '0, 1'b0, '0, 1'b1, {32'h0000_000A, 32'h0000_000B});
    check("single_no_error", 64'(DUT_error), 64'd0);

    // Contention: simultaneous pulses, then both ports again while the first read completes
    do_reset();
`ifdef DMEM_READ_ARB_FIXED_PRIO_EN
    order = '{29'h10, 29'h11, 29'h20, 29'h21};
`else
    order = '{29'h10, 29'h20, 29'h11, 29'h21};
`endif
    for (int k = 0; k < 4; k++) exp_issue.push_back(order[k]);
    exp_resp0.push_back(resp_of(29'h10));
    exp_resp0.push_back(resp_of(29'h11));
    exp_resp1.push_back(resp_of(29'h20));
    exp_resp1.push_back(resp_of(29'h21));
    drive_cycle(1'b1, 29'h10, 1'b1, 29'h20, 1'b0, '0);
    wait_issue("cont0");
    tick();
    drive_cycle(1'b1, 29'h11, 1'b1, 29'h21, 1'b1, resp_of(order[0]));
    for (int k = 1; k < 4; k++) begin
      wait_issue("cont");
      tick();
      drive_cycle(1'b0, '0, 1'b0, '0, 1'b1, resp_of(order[k]));
    end
    check("cont_no_error", 64'(DUT_error), 64'd0);

    // Back-pressure with port 1 overflow during the stall, then enqueue-while-pop when full
    do_reset();
    mem_read_req_ready = 1'b0;
    exp_issue.push_back(29'h300);
    exp_issue.push_back(29'h40);
    exp_issue.push_back(29'h41);
    exp_issue.push_back(29'h43);
    exp_resp0.push_back(resp_of(29'h300));
    exp_resp1.push_back(resp_of(29'h40));
    exp_resp1.push_back(resp_of(29'h41));
    exp_resp1.push_back(resp_of(29'h43));
    drive_cycle(1'b1, 29'h300, 1'b0, '0, 1'b0, '0);
    wait_issue("bp");
    for (int i = 0; i < 4; i++) begin
      check("bp_hold_valid", 64'(mem_read_req_valid), 64'd1);
      check("bp_hold_addr", 64'(mem_read_req_block_addr), 64'h300);
      if (i == 2) check("ovf_error_before", 64'(DUT_error), 64'd0);
      drive_cycle(1'b0, '0, (i < 3), AW'(29'h40 + i), 1'b0, '0);
    end
    check("ovf_error_after", 64'(DUT_error), 64'd1);
    check("bp_still_addr", 64'(mem_read_req_block_addr), 64'h300);
    mem_read_req_ready = 1'b1;
    tick();
    drive_cycle(1'b0, '0, 1'b0, '0, 1'b1, resp_of(29'h300));
    wait_issue("ovf_a");
    drive_cycle(1'b0, '0, 1'b1, 29'h43, 1'b0, '0);
    drive_cycle(1'b0, '0, 1'b0, '0, 1'b1, resp_of(29'h40));
    for (int k = 0; k < 2; k++) begin
      wait_issue("ovf_b");
      tick();
      drive_cycle(1'b0, '0, 1'b0, '0, 1'b1, resp_of(k == 0 ? 29'h41 : 29'h43));
    end
    repeat (4) tick();
    check("ovf_error_sticky", 64'(DUT_error), 64'd1);

    // Stray response in IDLE, then reset while a read is outstanding
    do_reset();
    drive_cycle(1'b0, '0, 1'b0, '0, 1'b1, 64'hDEAD_BEEF_0000_0001);
    check("stray_error", 64'(DUT_error), 64'd1);
    do_reset();
    exp_issue.push_back(29'h500);
    drive_cycle(1'b1, 29'h500, 1'b0, '0, 1'b0, '0);
    wait_issue("rst_wait");
    drive_cycle(1'b0, '0, 1'b1, 29'h600, 1'b0, '0);
    #2;
    nRST = 1'b0;
    tick();
    check("rstw_req_valid", 64'(mem_read_req_valid), 64'd0);
    check("rstw_error", 64'(DUT_error), 64'd0);
    nRST = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rstw_fifo_empty", 64'(mem_read_req_valid), 64'd0);
    end
    drive_cycle(1'b0, '0, 1'b0, '0, 1'b1, 64'h0123_4567_89AB_CDEF);
    check("rstw_stray_error", 64'(DUT_error), 64'd1);
    repeat (3) tick();

    check("sb_issue_drained", 64'(exp_issue.size()), 64'd0);
    check("sb_resp0_drained", 64'(exp_resp0.size()), 64'd0);
    check("sb_resp1_drained", 64'(exp_resp1.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
